fp_div_iter: RTL and testbench

Parametrised iterative floating-point divider, the successor to the fixed fp16 divider. It supports any IEEE-style format set by `EXP_W`/`MAN_W` (FP16, BF16, FP32) and handles special operands per IEEE. It also produces exception flags and rounds to nearest-even. It sits behind the NPU vector/activation datapath, uses the same start / valid / clear handshake, and has one operation in flight at a time.

---
 rtl/fp_div_pkg.sv | 35 +++
 rtl/fp_div_classify.sv | 35 +++
 rtl/fp_div_iter.sv | 249 ++++++++++++++++++++++++
 tb/tb_fp_div_iter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the iterative floating-point divider:
// FSM states, operand classes, flag bit positions and the canonical NaN.
package fp_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_DIV   = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    // Bit positions inside the 5-bit flags word.
    localparam int FLG_INV = 4;
    localparam int FLG_DZ  = 3;
    localparam int FLG_OF  = 2;
    localparam int FLG_UF  = 1;
    localparam int FLG_NX  = 0;

    // Quiet NaN with only the top mantissa bit set, zero-extended to 64 bits.
    // Callers truncate to their own word width.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_div_classify.sv
// Combinational unpack of one IEEE-style operand into sign, biased
// exponent, mantissa with hidden bit and class. Subnormals read as zero.
module fp_div_classify
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic [EXP_W+MAN_W:0] op,
    output logic                 sign,
    output logic [EXP_W-1:0]     exp,
    output logic [MAN_W:0]       mant,
    output logic [1:0]           cls
);

    logic [MAN_W-1:0] frac;
    cls_e             cls_v;

    assign sign = op[EXP_W+MAN_W];
    assign exp  = op[MAN_W +: EXP_W];
    assign frac = op[MAN_W-1:0];
    assign mant = {1'b1, frac};
    assign cls  = cls_v;

    // Classify from the exponent field; a zero exponent flushes to zero.
    always_comb begin
        cls_v = CLS_NORM;
        if (exp == '0) begin
            cls_v = CLS_ZERO;
        end else if (exp == '1) begin
            cls_v = (frac == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-style floating-point divider, one quotient bit per cycle.
// Start/valid/clear handshake, one operation in flight.
// Build option: FP_DIV_RNE_EN selects round-to-nearest-even; without it
// the quotient is truncated (guard/sticky still drive the inexact flag).
module fp_div_iter
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic [EXP_W+MAN_W:0] input_a,
    input  logic [EXP_W+MAN_W:0] input_b,
    input  logic                 start,
    input  logic                 clear,
    output logic                 busy,
    output logic                 valid,
    output logic [EXP_W+MAN_W:0] result,
    output logic [4:0]           flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int QW  = MAN_W + 2;            // remainder width
    localparam int EW2 = EXP_W + 2;            // signed working exponent
    localparam int CW  = $clog2(MAN_W + 3);
    localparam logic [EW2-1:0] BIAS_V = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW2-1:0] EMAX_V = EW2'((1 << EXP_W) - 1);
    localparam logic [W-1:0]   QNAN   = W'(canon_nan(EXP_W, MAN_W));
    localparam logic [CW-1:0]  ITERS  = CW'(MAN_W + 2);

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [QW-1:0]    rem_q, rem_d;
    // Fraction bits plus guard. The leading quotient bit is always 1 after
    // normalisation and simply shifts out of the top during DIV.
    logic [MAN_W:0]   quo_q, quo_d;
    logic [EW2-1:0]   exp_q, exp_d;
    logic             sign_q, sign_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             spec_q, spec_d;
    logic [W-1:0]     spec_res_q, spec_res_d;
    logic [4:0]       spec_flg_q, spec_flg_d;
    logic [W-1:0]     result_q, result_d;
    logic [4:0]       flags_q, flags_d;

    // Operand unpack
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W:0]   ma, mb;
    logic [1:0]       ca_w, cb_w;
    cls_e             ca, cb;

    fp_div_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .op(a_q), .sign(sa), .exp(ea), .mant(ma), .cls(ca_w)
    );

    fp_div_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .op(b_q), .sign(sb), .exp(eb), .mant(mb), .cls(cb_w)
    );

    assign ca = cls_e'(ca_w);
    assign cb = cls_e'(cb_w);

    // Prep datapath: raw exponent and normalisation test
    logic [EW2-1:0]   e_raw;
    logic             a_lt_b;
    logic             res_sign;

    assign e_raw    = {2'b00, ea} - {2'b00, eb} + BIAS_V;
    assign a_lt_b   = ma < mb;
    assign res_sign = sa ^ sb;

    // One restoring-division step
    logic             div_ge;
    logic [QW-1:0]    div_rem;

    assign div_ge  = rem_q >= {1'b0, mb};
    assign div_rem = div_ge ? (rem_q - {1'b0, mb}) : rem_q;

    // Rounding datapath
    logic             guard, sticky, rnd_inc, carry;
    logic [MAN_W-1:0] frac_r;
    logic [EW2-1:0]   exp_r;
    logic             exp_of, exp_uf;

    assign guard  = quo_q[0];
    assign sticky = |rem_q;
`ifdef FP_DIV_RNE_EN
    assign rnd_inc = guard & (sticky | quo_q[1]);
`else
    assign rnd_inc = 1'b0;
`endif
    // A carry out of the fraction means the mantissa reached 2.0: the
    // fraction wraps to zero and the exponent steps up by one.
    assign {carry, frac_r} = {1'b0, quo_q[MAN_W:1]} + {{MAN_W{1'b0}}, rnd_inc};
    assign exp_r  = exp_q + {{(EW2-1){1'b0}}, carry};
    assign exp_of = !exp_r[EW2-1] && (exp_r >= EMAX_V);
    assign exp_uf = exp_r[EW2-1] || (exp_r == '0);

    assign busy   = (state_q == ST_PREP) || (state_q == ST_DIV) || (state_q == ST_ROUND);
    assign valid  = (state_q == ST_DONE);
    assign result = result_q;
    assign flags  = flags_q;

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        spec_flg_d = spec_flg_q;
        result_d   = result_q;
        flags_d    = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (!clear && start) begin
                    a_d     = input_a;
                    b_d     = input_b;
                    state_d = ST_PREP;
                end
            end

            ST_PREP: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else begin
                    // Specials skip DIV; ROUND then registers the stored outcome.
                    spec_d     = 1'b1;
                    spec_flg_d = '0;
                    spec_res_d = '0;
                    state_d    = ST_ROUND;
                    if (ca == CLS_NAN || cb == CLS_NAN ||
                        (ca == CLS_ZERO && cb == CLS_ZERO) ||
                        (ca == CLS_INF && cb == CLS_INF)) begin
                        spec_res_d          = QNAN;
                        spec_flg_d[FLG_INV] = 1'b1;
                    end else if (ca == CLS_INF) begin
                        spec_res_d = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (cb == CLS_ZERO) begin
                        spec_res_d         = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        spec_flg_d[FLG_DZ] = 1'b1;
                    end else if (ca == CLS_ZERO || cb == CLS_INF) begin
                        spec_res_d = {res_sign, {(W-1){1'b0}}};
                    end else begin
                        // Pre-shift the dividend so the quotient lands in [1,2).
                        spec_d  = 1'b0;
                        sign_d  = res_sign;
                        exp_d   = a_lt_b ? (e_raw - EW2'(1)) : e_raw;
                        rem_d   = a_lt_b ? {ma, 1'b0} : {1'b0, ma};
                        quo_d   = '0;
                        cnt_d   = ITERS;
                        state_d = ST_DIV;
                    end
                end
            end

            ST_DIV: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = div_rem << 1;
                    quo_d = {quo_q[MAN_W-1:0], div_ge};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_ROUND;
                    end
                end
            end

            ST_ROUND: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    flags_d = '0;
                    if (spec_q) begin
                        result_d = spec_res_q;
                        flags_d  = spec_flg_q;
                    end else if (exp_of) begin
                        result_d         = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags_d[FLG_OF]  = 1'b1;
                        flags_d[FLG_NX]  = 1'b1;
                    end else if (exp_uf) begin
                        result_d         = {sign_q, {(W-1){1'b0}}};
                        flags_d[FLG_UF]  = 1'b1;
                        flags_d[FLG_NX]  = 1'b1;
                    end else begin
                        result_d         = {sign_q, exp_r[EXP_W-1:0], frac_r};
                        flags_d[FLG_NX]  = guard | sticky;
                    end
                end
            end

            ST_DONE: begin
                if (clear) begin
                    state_d  = ST_IDLE;
                    result_d = '0;
                    flags_d  = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            spec_flg_q <= '0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            spec_flg_q <= spec_flg_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Self-checking bench for fp_div_iter: FP16 and BF16 instances, a vector
// table, handshake/reset sequences and a random sweep against an exact
// integer-arithmetic division model.
module tb_fp_div_iter;

`ifdef FP_DIV_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    localparam logic [4:0] F_NX = 5'h01, F_UF = 5'h02, F_OF = 5'h04, F_DZ = 5'h08, F_INV = 5'h10;

    logic        clk = 1'b0;
    logic        reset_b;
    logic [15:0] a16, b16, a8, b8;
    logic        st16, cl16, st8, cl8;
    logic        busy16, val16, busy8, val8;
    logic [15:0] res16, res8;
    logic [4:0]  flg16, flg8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_div_iter #(.EXP_W(5), .MAN_W(10)) u16 (
        .clk(clk), .reset_b(reset_b), .input_a(a16), .input_b(b16),
        .start(st16), .clear(cl16), .busy(busy16), .valid(val16),
        .result(res16), .flags(flg16)
    );

    fp_div_iter #(.EXP_W(8), .MAN_W(7)) u8b (
        .clk(clk), .reset_b(reset_b), .input_a(a8), .input_b(b8),
        .start(st8), .clear(cl8), .busy(busy8), .valid(val8),
        .result(res8), .flags(flg8)
    );

    typedef struct {
        bit          bf;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [4:0]  flg;
        int          lat;
        string       name;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input bit bf, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] res, input logic [4:0] flg, input int lat,
                                input string name);
        vec_t v;
        v.bf = bf; v.a = a; v.b = b; v.res = res; v.flg = flg; v.lat = lat; v.name = name;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_ops(input bit bf, input logic [15:0] a, input logic [15:0] b);
        if (bf) begin a8 = a; b8 = b; end else begin a16 = a; b16 = b; end
    endtask

    task automatic set_start(input bit bf, input logic v);
        if (bf) st8 = v; else st16 = v;
    endtask

    task automatic set_clear(input bit bf, input logic v);
        if (bf) cl8 = v; else cl16 = v;
    endtask

    function automatic logic o_valid(input bit bf);
        return bf ? val8 : val16;
    endfunction

    function automatic logic [22:0] o_all(input bit bf);
        return bf ? {busy8, val8, flg8, res8} : {busy16, val16, flg16, res16};
    endfunction

    // Exact reference: quotient from integer division, round to nearest
    // by comparing twice the remainder with the divisor.
    function automatic void ref_div(input int ew, input int mw, input logic [15:0] a,
                                    input logic [15:0] b, output logic [15:0] res,
                                    output logic [4:0] flg);
        longint emax, bias, av, bv, ea, eb, fa, fb, sgn, qnan, inf, ma, mb, e, num, m, r;
        bit za, zb, ia, ib, na, nb, up;
        emax = (longint'(1) << ew) - 1;
        bias = (longint'(1) << (ew - 1)) - 1;
        av = longint'(a); bv = longint'(b);
        ea = (av >> mw) & emax;  eb = (bv >> mw) & emax;
        fa = av & ((longint'(1) << mw) - 1);  fb = bv & ((longint'(1) << mw) - 1);
        sgn = (((av ^ bv) >> (ew + mw)) & 1) << (ew + mw);
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == emax) && (fa == 0); ib = (eb == emax) && (fb == 0);
        na = (ea == emax) && (fa != 0); nb = (eb == emax) && (fb != 0);
        qnan = (emax << mw) | (longint'(1) << (mw - 1));
        inf  = sgn | (emax << mw);
        flg = '0;
        if (na || nb || (za && zb) || (ia && ib)) begin
            res = 16'(qnan); flg = F_INV;
        end else if (ia) begin
            res = 16'(inf);
        end else if (zb) begin
            res = 16'(inf); flg = F_DZ;
        end else if (za || ib) begin
            res = 16'(sgn);
        end else begin
            ma = (longint'(1) << mw) | fa;
            mb = (longint'(1) << mw) | fb;
            e = ea - eb + bias;
            if (ma < mb) begin
                num = ma << (mw + 1); e = e - 1;
            end else begin
                num = ma << mw;
            end
            m = num / mb;
            r = num % mb;
            up = RNE && ((2 * r > mb) || ((2 * r == mb) && (m % 2 == 1)));
            if (up) m = m + 1;
            if (m == (longint'(1) << (mw + 1))) begin
                m = longint'(1) << mw; e = e + 1;
            end
            if (e >= emax) begin
                res = 16'(inf); flg = F_OF | F_NX;
            end else if (e <= 0) begin
                res = 16'(sgn); flg = F_UF | F_NX;
            end else begin
                res = 16'(sgn | (e << mw) | (m & ((longint'(1) << mw) - 1)));
                flg = (r != 0) ? F_NX : 5'h00;
            end
        end
    endfunction

    function automatic logic [15:0] rnd_op(input int ew, input int mw);
        int bias;
        int ex;
        logic [15:0] v;
        bias = (1 << (ew - 1)) - 1;
        if ($urandom_range(0, 7) == 0) return 16'($urandom);
        ex = bias - 12 + int'($urandom_range(0, 24));
        v = 16'((int'($urandom_range(0, 1)) << (ew + mw)) | (ex << mw) |
                int'($urandom & ((32'd1 << mw) - 1)));
        return v;
    endfunction

    task automatic run_op(input bit bf, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output logic [4:0] flg, output int lat);
        logic [22:0] o;
        @(negedge clk);
        set_ops(bf, a, b);
        set_start(bf, 1'b1);
        @(posedge clk); #1;
        set_start(bf, 1'b0);
        set_ops(bf, 16'($urandom), 16'($urandom));
        lat = 0;
        while (!o_valid(bf) && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!o_valid(bf)) lat = -1;
        o = o_all(bf);
        res = o[15:0];
        flg = o[20:16];
    endtask

    task automatic clear_op(input bit bf, input string nm);
        @(negedge clk);
        set_clear(bf, 1'b1);
        @(posedge clk); #1;
        set_clear(bf, 1'b0);
        chk({nm, " clr"}, 32'(o_all(bf)), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r, er;
        logic [4:0]  f, ef;
        int          lat;
        logic [15:0] ra, rb;

        tv.push_back(mk(0, 16'h4600, 16'h4400, 16'h3E00, 5'h00, 14, "6/4"));
        tv.push_back(mk(0, 16'h4500, 16'h4200, RNE ? 16'h3EAB : 16'h3EAA, F_NX, 14, "5/3"));
        tv.push_back(mk(0, 16'h3C00, 16'h4200, 16'h3555, F_NX, 14, "1/3"));
        tv.push_back(mk(0, 16'h3C00, 16'h0000, 16'h7C00, F_DZ, 2, "1/0"));
        tv.push_back(mk(0, 16'hBC00, 16'h0000, 16'hFC00, F_DZ, 2, "-1/0"));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 16'h7E00, F_INV, 2, "0/0"));
        tv.push_back(mk(0, 16'hFC00, 16'h4000, 16'hFC00, 5'h00, 2, "-inf/2"));
        tv.push_back(mk(0, 16'h7C00, 16'h7C00, 16'h7E00, F_INV, 2, "inf/inf"));
        tv.push_back(mk(0, 16'h7E01, 16'h3C00, 16'h7E00, F_INV, 2, "nan/1"));
        tv.push_back(mk(0, 16'h7C00, 16'h0000, 16'h7C00, 5'h00, 2, "inf/0"));
        tv.push_back(mk(0, 16'h8000, 16'h3C00, 16'h8000, 5'h00, 2, "-0/1"));
        tv.push_back(mk(0, 16'h3C00, 16'hFC00, 16'h8000, 5'h00, 2, "1/-inf"));
        tv.push_back(mk(0, 16'h0001, 16'h3C00, 16'h0000, 5'h00, 2, "sub/1"));
        tv.push_back(mk(0, 16'h7BFF, 16'h3800, 16'h7C00, F_OF | F_NX, 14, "ovf"));
        tv.push_back(mk(0, 16'h0400, 16'h7BFF, 16'h0000, F_UF | F_NX, 14, "udf"));
        tv.push_back(mk(1, 16'h3F80, 16'h4040, RNE ? 16'h3EAB : 16'h3EAA, F_NX, 11, "bf 1/3"));
        tv.push_back(mk(1, 16'h4040, 16'h3F80, 16'h4040, 5'h00, 11, "bf 3/1"));

        reset_b = 1'b0;
        a16 = '0; b16 = '0; a8 = '0; b8 = '0;
        st16 = 1'b0; cl16 = 1'b0; st8 = 1'b0; cl8 = 1'b0;
        #12;
        chk("reset u16", 32'(o_all(0)), 32'h0);
        chk("reset bf16", 32'(o_all(1)), 32'h0);
        @(negedge clk);
        reset_b = 1'b1;

        // Vector table
        foreach (tv[i]) begin
            run_op(tv[i].bf, tv[i].a, tv[i].b, r, f, lat);
            chk({tv[i].name, " res"}, 32'(r), 32'(tv[i].res));
            chk({tv[i].name, " flags"}, 32'(f), 32'(tv[i].flg));
            chk({tv[i].name, " latency"}, 32'(lat), 32'(tv[i].lat));
            clear_op(tv[i].bf, tv[i].name);
        end

        // Start pulsed while busy and while done must be ignored
        @(negedge clk);
        set_ops(0, 16'h4600, 16'h4400);
        set_start(0, 1'b1);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        lat = 0;
        while (!val16 && lat < 60) begin
            if (lat == 3) begin
                set_ops(0, 16'h3C00, 16'h0000);
                set_start(0, 1'b1);
            end else begin
                set_start(0, 1'b0);
            end
            @(posedge clk); #1;
            lat++;
        end
        set_start(0, 1'b0);
        chk("busy-start res", 32'(res16), 32'h3E00);
        chk("busy-start latency", 32'(lat), 32'd14);
        set_ops(0, 16'h3C00, 16'h0000);
        set_start(0, 1'b1);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        chk("done-start hold", 32'({val16, res16}), 32'h13E00);
        @(posedge clk); #1;
        chk("done-start hold2", 32'({val16, res16}), 32'h13E00);
        clear_op(0, "done-start");

        // Clear during DIV cycle 5 aborts, then immediate restart
        @(negedge clk);
        set_ops(0, 16'h4600, 16'h4400);
        set_start(0, 1'b1);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort busy before", 32'(busy16), 32'h1);
        set_clear(0, 1'b1);
        @(posedge clk); #1;
        set_clear(0, 1'b0);
        chk("abort idle", 32'({busy16, val16}), 32'h0);
        run_op(0, 16'h3C00, 16'h4200, r, f, lat);
        chk("post-abort res", 32'(r), 32'h3555);
        chk("post-abort latency", 32'(lat), 32'd14);
        clear_op(0, "post-abort");

        // Asynchronous reset mid-DIV; the BF16 instance holds a result
        run_op(1, 16'h3F80, 16'h4040, r, f, lat);
        chk("pre-reset bf valid", 32'(val8), 32'h1);
        @(negedge clk);
        set_ops(0, 16'h4600, 16'h4400);
        set_start(0, 1'b1);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        reset_b = 1'b0;
        #1;
        chk("async reset u16", 32'(o_all(0)), 32'h0);
        chk("async reset bf16", 32'(o_all(1)), 32'h0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        run_op(0, 16'h4600, 16'h4400, r, f, lat);
        chk("post-reset res", 32'(r), 32'h3E00);
        chk("post-reset latency", 32'(lat), 32'd14);
        clear_op(0, "post-reset");

        // Random sweep against the reference model
        for (int n = 0; n < 100; n++) begin
            bit bf;
            bf = (n % 2) == 1;
            ra = bf ? rnd_op(8, 7) : rnd_op(5, 10);
            rb = bf ? rnd_op(8, 7) : rnd_op(5, 10);
            if (bf) ref_div(8, 7, ra, rb, er, ef);
            else    ref_div(5, 10, ra, rb, er, ef);
            run_op(bf, ra, rb, r, f, lat);
            chk($sformatf("rnd%0s %h/%h res", bf ? "bf" : "fp", ra, rb), 32'(r), 32'(er));
            chk($sformatf("rnd%0s %h/%h flags", bf ? "bf" : "fp", ra, rb), 32'(f), 32'(ef));
            clear_op(bf, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
